branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the fetch stage of the pipelined RV32 core. It replaces static not-taken fetch, where PC+4 is fetched until execute resolves the branch. A direct-mapped tagged branch target buffer with 2-bit saturating counters supplies a predicted next PC in the same cycle as the fetch PC. Execute-stage resolution trains the tables, flags mispredictions and keeps a running mispredict count.

## Interface
Parameters:
- XLEN, 32: address and target width.
- ENTRIES, 64: BTB and counter table depth. Must be a power of two and at least 4. IDX_W = $clog2(ENTRIES).
- TAG_W, 8: stored tag width. Requires IDX_W + TAG_W + 2 <= XLEN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- pc_f  in  XLEN  fetch-stage PC.
- pred_taken_f  out  1  prediction for pc_f is taken.
- pred_target_f  out  XLEN  predicted next PC: the stored target if pred_taken_f is 1, otherwise pc_f+4.
- upd_valid_e  in  1  a control transfer resolved in execute this cycle.
- upd_pc_e  in  XLEN  PC of the resolved instruction.
- upd_is_jump_e  in  1  1 for JAL/JALR, 0 for a conditional branch.
- upd_taken_e  in  1  resolved direction. Must be 1 for jumps.
- upd_target_e  in  XLEN  resolved taken target.
- upd_pred_taken_e  in  1  pred_taken_f carried down the pipe to execute.
- upd_pred_target_e  in  XLEN  pred_target_f carried down the pipe to execute.
- mispredict_e  out  1  the redirect was wrong; execute flushes D/E.
- recover_pc_e  out  XLEN  correct next PC: upd_target_e if taken, otherwise upd_pc_e+4.
- mispredict_count  out  32  count of mispredicts since reset.

## Operation
- Index and tag fields:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds valid, tag, target[XLEN-1:0], is_jump and ctr[1:0].
- Lookup is combinational from registered state.
  - hit = valid[idx] & (tag[idx] == tag(pc_f)).
  - pred_taken_f = hit & (is_jump[idx] | ctr[idx][1]).
- mispredict_e = upd_valid_e & ((upd_taken_e != upd_pred_taken_e) | (upd_taken_e & upd_pred_target_e != upd_target_e)). It is 0 whenever upd_valid_e is 0.
- Training happens at the clock edge when upd_valid_e is 1. hit_u below is the lookup of upd_pc_e.
  - Taken and hit_u: write target and is_jump, and saturating-increment ctr (3 stays 3).
  - Taken and not hit_u: allocate the entry. Set valid=1 and write tag, target and is_jump. Set ctr=2'b10.
  - Not taken and hit_u, conditional branch: saturating-decrement ctr (0 stays 0). Leave target unchanged.
  - Not taken and not hit_u: no table change.
- mispredict_count increments by 1 on each cycle where mispredict_e is 1. It wraps from 32'hFFFF_FFFF to 0.
- No other state changes. Stall and flush belong to the hazard unit: a flushed instruction never asserts upd_valid_e.

## Timing
- Lookup has zero latency: pred_taken_f and pred_target_f are valid in the same cycle as pc_f.
- mispredict_e and recover_pc_e are combinational from the upd_* inputs, in the same cycle.
- A table write is visible to lookup on the cycle after the update edge. If lookup and update hit the same index in the same cycle, the lookup returns the pre-update contents.
- Aliasing: a different tag at the same index overwrites the entry only on a taken update. On a tag mismatch the lookup predicts not-taken.
- Asynchronous reset takes effect immediately, including mid-operation:
  - all valid=0, all ctr=2'b01, GHR=0 and mispredict_count=0;
  - pred_taken_f=0 and pred_target_f=pc_f+4 while reset is held and afterwards until training occurs.
- Address arithmetic (pc_f+4, upd_pc_e+4) is modulo 2^XLEN: PC 'hFFFF_FFFC gives 0.

## Configuration
- BP_GSHARE_EN defined:
  - An IDX_W-bit global history register shifts left with upd_taken_e on every update of a conditional branch (upd_valid_e=1, upd_is_jump_e=0).
  - The counter table is indexed by idx ^ GHR, both on lookup and on training. BTB valid, tag, target and is_jump stay indexed by idx.
  - The GHR resets to 0.
- BP_GSHARE_EN undefined:
  - There is no GHR.
  - Counters are indexed by idx.

## Test plan
- Reset hold: hold reset=0 and drive pc_f='h100. Required: pred_taken_f=0, pred_target_f='h104, mispredict_count=0.
- Cold taken branch: update PC 'h100, taken, target 'h80, predicted not-taken. Required: mispredict_e=1 and recover_pc_e='h80 in that cycle. Next cycle, pc_f='h100 gives pred_taken_f=1 and pred_target_f='h80.
- Counter saturation: train 'h100 taken 4 more times, then not-taken once. Required: still predicts taken (ctr 3 to 2). After a second not-taken it predicts not-taken. Two more not-taken leave ctr=0, and it then takes 2 taken updates to predict taken again.
- Jump and alias: JAL at 'h200 is trained with target 'h400. Then PC 'h200 + (ENTRIES*4), same index with a different tag, is trained taken with target 'h500. Required: a lookup of 'h200 now misses and predicts not-taken, with pred_target_f='h204.
- Same-cycle collision: present pc_f='h100 in the same cycle as its first taken update. Required: that cycle shows pred_taken_f=0, and the following cycle shows pred_taken_f=1.
- Counter wrap: force mispredict_count to 32'hFFFF_FFFF, then cause one mispredict. Required: mispredict_count=0. With BP_GSHARE_EN defined, alternating T/N at one PC must reach zero mispredicts after warm-up.

Source files
------------

// File: rtl/branch_predictor.sv
`timescale 1ns/1ps
// Direct-mapped tagged BTB with 2-bit saturating counters for the fetch stage.
// Define BP_GSHARE_EN to index the counter table by pc index XOR global history.
module branch_predictor #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            upd_valid_e,
  input  logic [XLEN-1:0] upd_pc_e,
  input  logic            upd_is_jump_e,
  input  logic            upd_taken_e,
  input  logic [XLEN-1:0] upd_target_e,
  input  logic            upd_pred_taken_e,
  input  logic [XLEN-1:0] upd_pred_target_e,
  output logic            mispredict_e,
  output logic [XLEN-1:0] recover_pc_e,
  output logic [31:0]     mispredict_count
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [XLEN-1:0]   tgt_q   [ENTRIES];
  logic              jmp_q   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];
  logic [31:0]       mis_cnt_q;

  logic [IdxW-1:0]  idx_f, idx_u, cidx_f, cidx_u;
  logic [TAG_W-1:0] tag_f, tag_u;
  logic             hit_f, hit_u;

  assign idx_f = pc_f[IdxW+1:2];
  assign tag_f = pc_f[IdxW+TAG_W+1:IdxW+2];
  assign idx_u = upd_pc_e[IdxW+1:2];
  assign tag_u = upd_pc_e[IdxW+TAG_W+1:IdxW+2];

`ifdef BP_GSHARE_EN
  logic [IdxW-1:0] ghr_q;

  assign cidx_f = idx_f ^ ghr_q;
  assign cidx_u = idx_u ^ ghr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else if (upd_valid_e && !upd_is_jump_e) begin
      ghr_q <= {ghr_q[IdxW-2:0], upd_taken_e};
    end
  end
`else
  assign cidx_f = idx_f;
  assign cidx_u = idx_u;
`endif

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_u = valid_q[idx_u] && (tag_q[idx_u] == tag_u);

  assign pred_taken_f  = hit_f && (jmp_q[idx_f] || ctr_q[cidx_f][1]);
  assign pred_target_f = pred_taken_f ? tgt_q[idx_f] : pc_f + XLEN'(4);

  assign mispredict_e = upd_valid_e && ((upd_taken_e != upd_pred_taken_e) ||
                        (upd_taken_e && (upd_pred_target_e != upd_target_e)));
  assign recover_pc_e = upd_taken_e ? upd_target_e : upd_pc_e + XLEN'(4);

  assign mispredict_count = mis_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        jmp_q[i]   <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_valid_e) begin
      if (upd_taken_e) begin
        tgt_q[idx_u] <= upd_target_e;
        jmp_q[idx_u] <= upd_is_jump_e;
        if (hit_u) begin
          ctr_q[cidx_u] <= (ctr_q[cidx_u] == 2'b11) ? 2'b11 : ctr_q[cidx_u] + 2'b01;
        end else begin
          valid_q[idx_u] <= 1'b1;
          tag_q[idx_u]   <= tag_u;
          ctr_q[cidx_u]  <= 2'b10;
        end
      end else if (hit_u && !upd_is_jump_e) begin
        ctr_q[cidx_u] <= (ctr_q[cidx_u] == 2'b00) ? 2'b00 : ctr_q[cidx_u] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_cnt_q <= '0;
    end else if (mispredict_e) begin
      mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        upd_valid_e;
  logic [31:0] upd_pc_e;
  logic        upd_is_jump_e;
  logic        upd_taken_e;
  logic [31:0] upd_target_e;
  logic        upd_pred_taken_e;
  logic [31:0] upd_pred_target_e;
  logic        mispredict_e;
  logic [31:0] recover_pc_e;
  logic [31:0] mispredict_count;

  int nchk = 0;
  int nerr = 0;
  int exp_cnt = 0;

  branch_predictor dut (
    .clk               (clk),
    .reset             (reset),
    .pc_f              (pc_f),
    .pred_taken_f      (pred_taken_f),
    .pred_target_f     (pred_target_f),
    .upd_valid_e       (upd_valid_e),
    .upd_pc_e          (upd_pc_e),
    .upd_is_jump_e     (upd_is_jump_e),
    .upd_taken_e       (upd_taken_e),
    .upd_target_e      (upd_target_e),
    .upd_pred_taken_e  (upd_pred_taken_e),
    .upd_pred_target_e (upd_pred_target_e),
    .mispredict_e      (mispredict_e),
    .recover_pc_e      (recover_pc_e),
    .mispredict_count  (mispredict_count)
  );

  always #5 clk = ~clk;

  // Drive an update, let combinational outputs settle (checks happen before commit).
  task automatic upd_drive(input logic [31:0] pc, input logic j, input logic t,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    upd_valid_e       = 1'b1;
    upd_pc_e          = pc;
    upd_is_jump_e     = j;
    upd_taken_e       = t;
    upd_target_e      = tgt;
    upd_pred_taken_e  = pt;
    upd_pred_target_e = ptgt;
    #1;
  endtask

  task automatic upd_commit();
    @(posedge clk);
    #1;
    upd_valid_e = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    exp_cnt = 0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pc_f = 32'h100;
    upd_valid_e = 1'b0; upd_pc_e = '0; upd_is_jump_e = 1'b0; upd_taken_e = 1'b0;
    upd_target_e = '0; upd_pred_taken_e = 1'b0; upd_pred_target_e = '0;
    repeat (2) @(posedge clk);
    #1;
    nchk++; if (pred_taken_f !== 1'b0) begin nerr++;
      $display("FAIL reset_taken: got %b want 0", pred_taken_f); end
    nchk++; if (pred_target_f !== 32'h104) begin nerr++;
      $display("FAIL reset_target: got %h want 104", pred_target_f); end
    nchk++; if (mispredict_count !== 32'd0) begin nerr++;
      $display("FAIL reset_count: got %0d want 0", mispredict_count); end
    nchk++; if (mispredict_e !== 1'b0) begin nerr++;
      $display("FAIL reset_mispredict: got %b want 0", mispredict_e); end
    reset = 1'b1;
    #1;
  endtask

  // First taken update of 'h100 with pc_f='h100 presented in the same cycle.
  task automatic test_cold_taken_collision();
    pc_f = 32'h100;
    upd_drive(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    exp_cnt++;
    nchk++; if (mispredict_e !== 1'b1) begin nerr++;
      $display("FAIL cold_mispredict: got %b want 1", mispredict_e); end
    nchk++; if (recover_pc_e !== 32'h80) begin nerr++;
      $display("FAIL cold_recover: got %h want 80", recover_pc_e); end
    nchk++; if (pred_taken_f !== 1'b0) begin nerr++;
      $display("FAIL collision_pre: got %b want 0", pred_taken_f); end
    upd_commit();
    nchk++; if (pred_taken_f !== 1'b1) begin nerr++;
      $display("FAIL cold_pred_taken: got %b want 1", pred_taken_f); end
    nchk++; if (pred_target_f !== 32'h80) begin nerr++;
      $display("FAIL cold_pred_target: got %h want 80", pred_target_f); end
    nchk++; if (mispredict_count !== 32'(exp_cnt)) begin nerr++;
      $display("FAIL cold_count: got %0d want %0d", mispredict_count, exp_cnt); end
  endtask

  task automatic test_saturation();
    pc_f = 32'h100;
    for (int i = 0; i < 4; i++) begin
      upd_drive(32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
      nchk++; if (mispredict_e !== 1'b0) begin nerr++;
        $display("FAIL sat_correct_%0d: got %b want 0", i, mispredict_e); end
      upd_commit();
    end
    upd_drive(32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    exp_cnt++;
    nchk++; if (recover_pc_e !== 32'h104) begin nerr++;
      $display("FAIL sat_recover_nt: got %h want 104", recover_pc_e); end
    upd_commit();
    nchk++; if (pred_taken_f !== 1'b1) begin nerr++;
      $display("FAIL sat_ctr2: got %b want 1", pred_taken_f); end
    upd_drive(32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    exp_cnt++;
    upd_commit();
    nchk++; if (pred_taken_f !== 1'b0) begin nerr++;
      $display("FAIL sat_ctr1: got %b want 0", pred_taken_f); end
    nchk++; if (pred_target_f !== 32'h104) begin nerr++;
      $display("FAIL sat_ctr1_target: got %h want 104", pred_target_f); end
    for (int i = 0; i < 2; i++) begin
      upd_drive(32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
      upd_commit();
    end
    upd_drive(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    exp_cnt++;
    upd_commit();
    nchk++; if (pred_taken_f !== 1'b0) begin nerr++;
      $display("FAIL sat_from0_one: got %b want 0", pred_taken_f); end
    upd_drive(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    exp_cnt++;
    upd_commit();
    nchk++; if (pred_taken_f !== 1'b1) begin nerr++;
      $display("FAIL sat_from0_two: got %b want 1", pred_taken_f); end
    nchk++; if (mispredict_count !== 32'(exp_cnt)) begin nerr++;
      $display("FAIL sat_count: got %0d want %0d", mispredict_count, exp_cnt); end
  endtask

  task automatic test_jump_alias();
    upd_drive(32'h200, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204);
    exp_cnt++;
    upd_commit();
    pc_f = 32'h200;
    #1;
    nchk++; if (pred_target_f !== 32'h400) begin nerr++;
      $display("FAIL jal_target: got %h want 400", pred_target_f); end
    // 'h300 shares the index of 'h200 (64 entries * 4 bytes) with a different tag.
    upd_drive(32'h300, 1'b0, 1'b1, 32'h500, 1'b0, 32'h304);
    exp_cnt++;
    upd_commit();
    nchk++; if (pred_taken_f !== 1'b0) begin nerr++;
      $display("FAIL alias_miss_taken: got %b want 0", pred_taken_f); end
    nchk++; if (pred_target_f !== 32'h204) begin nerr++;
      $display("FAIL alias_miss_target: got %h want 204", pred_target_f); end
    upd_drive(32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h204);
    nchk++; if (mispredict_e !== 1'b0) begin nerr++;
      $display("FAIL alias_nt_mispredict: got %b want 0", mispredict_e); end
    upd_commit();
    pc_f = 32'h300;
    #1;
    nchk++; if (pred_target_f !== 32'h500) begin nerr++;
      $display("FAIL alias_keep_target: got %h want 500", pred_target_f); end
    upd_drive(32'h300, 1'b0, 1'b1, 32'h500, 1'b1, 32'h999);
    exp_cnt++;
    nchk++; if (mispredict_e !== 1'b1) begin nerr++;
      $display("FAIL wrong_target_mispredict: got %b want 1", mispredict_e); end
    upd_commit();
    nchk++; if (mispredict_count !== 32'(exp_cnt)) begin nerr++;
      $display("FAIL alias_count: got %0d want %0d", mispredict_count, exp_cnt); end
  endtask

  task automatic test_addr_wrap();
    pc_f = 32'hFFFF_FFFC;
    upd_drive(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    exp_cnt++;
    nchk++; if (pred_target_f !== 32'h0) begin nerr++;
      $display("FAIL wrap_pred_target: got %h want 0", pred_target_f); end
    nchk++; if (recover_pc_e !== 32'h0) begin nerr++;
      $display("FAIL wrap_recover: got %h want 0", recover_pc_e); end
    nchk++; if (mispredict_e !== 1'b1) begin nerr++;
      $display("FAIL wrap_mispredict: got %b want 1", mispredict_e); end
    upd_commit();
    nchk++; if (mispredict_count !== 32'(exp_cnt)) begin nerr++;
      $display("FAIL wrap_count: got %0d want %0d", mispredict_count, exp_cnt); end
  endtask

  task automatic test_mid_reset();
    upd_drive(32'h600, 1'b1, 1'b1, 32'h700, 1'b0, 32'h604);
    exp_cnt++;
    upd_commit();
    pc_f = 32'h600;
    #1;
    nchk++; if (pred_target_f !== 32'h700) begin nerr++;
      $display("FAIL midrst_trained: got %h want 700", pred_target_f); end
    #1;
    reset = 1'b0;
    #1;
    exp_cnt = 0;
    nchk++; if (pred_taken_f !== 1'b0) begin nerr++;
      $display("FAIL midrst_taken: got %b want 0", pred_taken_f); end
    nchk++; if (pred_target_f !== 32'h604) begin nerr++;
      $display("FAIL midrst_target: got %h want 604", pred_target_f); end
    nchk++; if (mispredict_count !== 32'd0) begin nerr++;
      $display("FAIL midrst_count: got %0d want 0", mispredict_count); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    nchk++; if (pred_taken_f !== 1'b0) begin nerr++;
      $display("FAIL midrst_after: got %b want 0", pred_taken_f); end
  endtask

  task automatic test_count_wrap();
    force dut.mis_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mis_cnt_q;
    #1;
    nchk++; if (mispredict_count !== 32'hFFFF_FFFF) begin nerr++;
      $display("FAIL cnt_forced: got %h want ffffffff", mispredict_count); end
    upd_drive(32'h800, 1'b0, 1'b1, 32'h900, 1'b0, 32'h804);
    upd_commit();
    nchk++; if (mispredict_count !== 32'h0) begin nerr++;
      $display("FAIL cnt_wrap: got %h want 0", mispredict_count); end
    upd_drive(32'h800, 1'b0, 1'b0, 32'h900, 1'b0, 32'h804);
    upd_commit();
    nchk++; if (mispredict_count !== 32'h0) begin nerr++;
      $display("FAIL cnt_hold: got %h want 0", mispredict_count); end
  endtask

`ifdef BP_GSHARE_EN
  task automatic test_gshare_alternate();
    int late_mis = 0;
    logic pt;
    logic [31:0] ptgt;
    pc_f = 32'h140;
    for (int i = 0; i < 24; i++) begin
      #1;
      pt = pred_taken_f;
      ptgt = pred_target_f;
      upd_drive(32'h140, 1'b0, (i % 2) == 0, 32'h40, pt, ptgt);
      if (i >= 12 && mispredict_e) late_mis++;
      upd_commit();
    end
    nchk++; if (late_mis !== 0) begin nerr++;
      $display("FAIL gshare_alternate: got %0d mispredicts want 0", late_mis); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef BP_GSHARE_EN
    test_cold_taken_collision();
    test_saturation();
    test_jump_alias();
`endif
    test_addr_wrap();
    test_mid_reset();
    test_count_wrap();
`ifdef BP_GSHARE_EN
    do_reset();
    test_gshare_alternate();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
